// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl
//   APB requester. Commands arrive on a valid/ready stream, are buffered in a
//   small FIFO and issued as SETUP/ACCESS transfers. The bus has no PREADY, so
//   ACCESS lasts a fixed ACCESS_CYCLES cycles. Each completion raises a
//   one-cycle rsp_valid strobe carrying the direction and, for reads, PRDATA.
//
// Ports
//   PCLK, PRESETn                  clock, async active-low reset
//   cmd_valid/cmd_ready            command handshake (cmd_ready = FIFO not full)
//   cmd_write/cmd_addr/cmd_wdata   command payload
//   PADDR/PSELx/PENABLE/PWRITE/PWDATA  registered APB request outputs
//   PRDATA                         APB read data
//   rsp_valid/rsp_write/rsp_rdata  completion strobe and payload
//   busy                           FIFO non-empty or transfer in progress
//
// States
//   state  | meaning
//   IDLE   | bus idle; pops the FIFO head when one is available
//   SETUP  | PSELx=1, PENABLE=0; always moves to ACCESS next edge
//   ACCESS | PSELx=1, PENABLE=1; counts down, completes at zero

`ifndef addrWidth
`define addrWidth 32
`endif
`ifndef dataWidth
`define dataWidth 32
`endif

module apb_master_ctrl #(
   parameter int ADDR_W        = `addrWidth,
   parameter int DATA_W        = `dataWidth,
   parameter int DEPTH         = 4,
   parameter int ACCESS_CYCLES = 1
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PSELx,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = 1 + ADDR_W + DATA_W;
   localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [ENT_W-1:0] fifo_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             full, empty, push, pop;

   logic [ENT_W-1:0]  head;
   logic              head_write;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_wdata;

   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              psel_nxt, penable_nxt;
   logic              rsp_valid_nxt, rsp_write_nxt;
   logic [DATA_W-1:0] rsp_rdata_nxt;

   // ---------------------------------------------------------------- FIFO
   assign full      = (count == (PTR_W+1)'(DEPTH));
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   // Full blocks the push even when a pop frees a slot on the same edge.
   assign push      = cmd_valid && !full;

   assign head       = fifo_mem[rd_ptr];
   assign head_write = head[ENT_W-1];
   assign head_addr  = head[DATA_W +: ADDR_W];
   assign head_wdata = head[DATA_W-1:0];

   always_ff @(posedge PCLK) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign busy = !empty || (state != IDLE);

   // ----------------------------------------------------------------- FSM
   always_comb begin
      state_nxt     = state;
      pop           = 1'b0;
      cnt_nxt       = cnt;
      psel_nxt      = PSELx;
      penable_nxt   = PENABLE;
      rsp_valid_nxt = 1'b0;
      rsp_write_nxt = rsp_write;
      rsp_rdata_nxt = rsp_rdata;

      case (state)
         IDLE: begin
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
            if (!empty) begin
               pop       = 1'b1;
               psel_nxt  = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            psel_nxt    = 1'b1;
            penable_nxt = 1'b1;
            cnt_nxt     = CNT_W'(ACCESS_CYCLES - 1);
            state_nxt   = ACCESS;
         end
         ACCESS: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else begin
               penable_nxt   = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_write_nxt = PWRITE;
               if (!PWRITE) rsp_rdata_nxt = PRDATA;
               // Chain straight into the next SETUP when work is queued.
               if (!empty) begin
                  pop       = 1'b1;
                  psel_nxt  = 1'b1;
                  state_nxt = SETUP;
               end else begin
                  psel_nxt  = 1'b0;
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
            state_nxt   = IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state     <= IDLE;
         cnt       <= '0;
         PSELx     <= 1'b0;
         PENABLE   <= 1'b0;
         PADDR     <= '0;
         PWRITE    <= 1'b0;
         PWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         PSELx     <= psel_nxt;
         PENABLE   <= penable_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_write <= rsp_write_nxt;
         rsp_rdata <= rsp_rdata_nxt;
         if (pop) begin
            PADDR  <= head_addr;
            PWRITE <= head_write;
            PWDATA <= head_wdata;
         end
      end
   end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl. Three instances share clock, reset and
// command payload, each with its own cmd_valid: u1 (ACCESS_CYCLES=1),
// u3 (ACCESS_CYCLES=3) and u8 (ACCESS_CYCLES=8). The slave returns
// PRDATA = 9*PADDR*PADDR, so address 4 reads back 144.

module tb_apb_master_ctrl;

   localparam int AW = 8;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;

   logic          v1 = 1'b0, v3 = 1'b0, v8 = 1'b0;
   logic          rdy1, rdy3, rdy8;
   logic [AW-1:0] pa1, pa3, pa8;
   logic          ps1, ps3, ps8, pe1, pe3, pe8, pw1, pw3, pw8;
   logic [DW-1:0] pwd1, pwd3, pwd8, prd1, prd3, prd8;
   logic          rv1, rv3, rv8, rw1, rw3, rw8, bz1, bz3, bz8;
   logic [DW-1:0] rd1, rd3, rd8;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign prd1 = DW'(pa1) * DW'(pa1) * 32'd9;
   assign prd3 = DW'(pa3) * DW'(pa3) * 32'd9;
   assign prd8 = DW'(pa8) * DW'(pa8) * 32'd9;

   apb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .ACCESS_CYCLES(1)) u1 (
      .PCLK(clk), .PRESETn(rst_n), .cmd_valid(v1), .cmd_ready(rdy1),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .PADDR(pa1), .PSELx(ps1), .PENABLE(pe1), .PWRITE(pw1), .PWDATA(pwd1),
      .PRDATA(prd1), .rsp_valid(rv1), .rsp_write(rw1), .rsp_rdata(rd1), .busy(bz1));

   apb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .ACCESS_CYCLES(3)) u3 (
      .PCLK(clk), .PRESETn(rst_n), .cmd_valid(v3), .cmd_ready(rdy3),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .PADDR(pa3), .PSELx(ps3), .PENABLE(pe3), .PWRITE(pw3), .PWDATA(pwd3),
      .PRDATA(prd3), .rsp_valid(rv3), .rsp_write(rw3), .rsp_rdata(rd3), .busy(bz3));

   apb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .ACCESS_CYCLES(8)) u8 (
      .PCLK(clk), .PRESETn(rst_n), .cmd_valid(v8), .cmd_ready(rdy8),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .PADDR(pa8), .PSELx(ps8), .PENABLE(pe8), .PWRITE(pw8), .PWDATA(pwd8),
      .PRDATA(prd8), .rsp_valid(rv8), .rsp_write(rw8), .rsp_rdata(rd8), .busy(bz8));

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] exp_rd8 [6];
      logic [4:0]    exp_pe3;
      logic [4:0]    exp_rv3;
      int            pushed, got_rsp, cyc;
      logic          rdy_pre, v_pre, saw_rsp, saw_busy;

      // ---------------- reset values
      tick(); tick();
      chk_val("rst_psel",    ps1,  0);
      chk_val("rst_penable", pe1,  0);
      chk_val("rst_paddr",   pa1,  0);
      chk_val("rst_pwdata",  pwd1, 0);
      chk_val("rst_pwrite",  pw1,  0);
      chk_val("rst_rsp_v",   rv1,  0);
      chk_val("rst_rsp_w",   rw1,  0);
      chk_val("rst_rsp_d",   rd1,  0);
      chk_val("rst_busy",    bz1,  0);
      chk_val("rst_ready",   rdy1, 1);
      rst_n = 1'b1;
      tick();
      chk_val("idle_busy", bz1, 0);

      // ---------------- single write addr 1 data 1, ACCESS_CYCLES=1
      set_cmd(1'b1, 8'd1, 32'd1); v1 = 1'b1;
      tick();                                   // E0
      v1 = 1'b0;
      chk_val("w_e0_psel", ps1, 0);
      chk_val("w_e0_busy", bz1, 1);
      tick();                                   // E1
      chk_val("w_e1_psel", ps1, 1);
      chk_val("w_e1_pen",  pe1, 0);
      chk_val("w_e1_pwr",  pw1, 1);
      chk_val("w_e1_addr", pa1, 1);
      chk_val("w_e1_wd",   pwd1, 1);
      tick();                                   // E2
      chk_val("w_e2_psel", ps1, 1);
      chk_val("w_e2_pen",  pe1, 1);
      chk_val("w_e2_rv",   rv1, 0);
      tick();                                   // E3
      chk_val("w_e3_psel", ps1, 0);
      chk_val("w_e3_pen",  pe1, 0);
      chk_val("w_e3_rv",   rv1, 1);
      chk_val("w_e3_rw",   rw1, 1);
      chk_val("w_e3_busy", bz1, 0);
      tick();
      chk_val("w_e4_rv",   rv1, 0);

      // ---------------- single read addr 4
      set_cmd(1'b0, 8'd4, 32'd0); v1 = 1'b1;
      tick();                                   // E0
      v1 = 1'b0;
      tick();                                   // E1
      chk_val("r_e1_pwr",  pw1, 0);
      chk_val("r_e1_addr", pa1, 4);
      tick(); tick();                           // E3
      chk_val("r_e3_rv",   rv1, 1);
      chk_val("r_e3_rw",   rw1, 0);
      chk_val("r_e3_rd",   rd1, 144);
      tick();
      chk_val("r_e4_rv",   rv1, 0);

      // ---------------- three back-to-back: write 4/144, read 4, write 1/0
      set_cmd(1'b1, 8'd4, 32'd144); v1 = 1'b1;
      tick();                                   // E0
      set_cmd(1'b0, 8'd4, 32'd0);
      tick();                                   // E1
      chk_val("b_e1_psel", ps1, 1);
      set_cmd(1'b1, 8'd1, 32'd0);
      tick();                                   // E2
      v1 = 1'b0;
      chk_val("b_e2_pwd",  pwd1, 144);
      tick();                                   // E3
      chk_val("b_e3_rv",   rv1, 1);
      chk_val("b_e3_rw",   rw1, 1);
      chk_val("b_e3_psel", ps1, 1);
      chk_val("b_e3_pen",  pe1, 0);
      chk_val("b_e3_addr", pa1, 4);
      chk_val("b_e3_pwr",  pw1, 0);
      tick();                                   // E4
      chk_val("b_e4_psel", ps1, 1);
      chk_val("b_e4_rv",   rv1, 0);
      tick();                                   // E5
      chk_val("b_e5_rv",   rv1, 1);
      chk_val("b_e5_rw",   rw1, 0);
      chk_val("b_e5_rd",   rd1, 144);
      chk_val("b_e5_psel", ps1, 1);
      chk_val("b_e5_addr", pa1, 1);
      chk_val("b_e5_pwr",  pw1, 1);
      chk_val("b_e5_pwd",  pwd1, 0);
      tick();                                   // E6
      chk_val("b_e6_psel", ps1, 1);
      tick();                                   // E7
      chk_val("b_e7_rv",   rv1, 1);
      chk_val("b_e7_rw",   rw1, 1);
      chk_val("b_e7_rd",   rd1, 144);           // write holds prior read data
      chk_val("b_e7_psel", ps1, 0);
      tick();

      // ---------------- ACCESS_CYCLES=3, single read addr 5 -> 225
      exp_pe3 = 5'b01110;                       // after E1..E5, bit i = E(i+1)
      exp_rv3 = 5'b10000;
      set_cmd(1'b0, 8'd5, 32'd0); v3 = 1'b1;
      tick();                                   // E0
      v3 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_val($sformatf("a3_pen_e%0d", i + 1), pe3, exp_pe3[i]);
         chk_val($sformatf("a3_rv_e%0d",  i + 1), rv3, exp_rv3[i]);
      end
      chk_val("a3_rd",   rd3, 225);
      chk_val("a3_psel", ps3, 0);
      tick();
      chk_val("a3_rv_e6", rv3, 0);

      // ---------------- DEPTH=4, ACCESS_CYCLES=8, 6 reads addr 2..7
      exp_rd8[0] = 32'd36;  exp_rd8[1] = 32'd81;  exp_rd8[2] = 32'd144;
      exp_rd8[3] = 32'd225; exp_rd8[4] = 32'd324; exp_rd8[5] = 32'd441;
      pushed = 0; got_rsp = 0; cyc = 0;
      while (got_rsp < 6 && cyc < 200) begin
         if (pushed < 6) begin
            set_cmd(1'b0, AW'(pushed + 2), 32'd0);
            v8 = 1'b1;
         end else begin
            v8 = 1'b0;
         end
         rdy_pre = rdy8;
         v_pre   = v8;
         tick();
         cyc++;
         if (rdy_pre && v_pre) begin
            pushed++;
            if (pushed == 4) chk_val("f_ready_after4", rdy8, 1);
            if (pushed == 5) chk_val("f_ready_after5", rdy8, 0);
         end
         if (rv8) begin
            chk_val($sformatf("f_rd%0d", got_rsp), rd8, exp_rd8[got_rsp]);
            chk_val($sformatf("f_rw%0d", got_rsp), rw8, 0);
            got_rsp++;
         end
      end
      v8 = 1'b0;
      chk_val("f_pushed", pushed, 6);
      chk_val("f_rsp_cnt", got_rsp, 6);
      tick();
      chk_val("f_busy_end", bz8, 0);

      // ---------------- reset mid-ACCESS with 2 commands queued (u8)
      set_cmd(1'b1, 8'd10, 32'd1); v8 = 1'b1;
      tick();                                   // E0
      set_cmd(1'b1, 8'd11, 32'd2);
      tick();                                   // E1
      set_cmd(1'b1, 8'd12, 32'd3);
      tick();                                   // E2
      v8 = 1'b0;
      tick();                                   // E3, in ACCESS
      chk_val("x_pre_pen",  pe8, 1);
      chk_val("x_pre_psel", ps8, 1);
      #3 rst_n = 1'b0;
      #1;                                       // no clock edge since assertion
      chk_val("x_psel",  ps8, 0);
      chk_val("x_pen",   pe8, 0);
      chk_val("x_busy",  bz8, 0);
      chk_val("x_ready", rdy8, 1);
      chk_val("x_rv",    rv8, 0);
      tick(); tick();
      rst_n = 1'b1;
      set_cmd(1'b1, 8'd3, 32'd7); v1 = 1'b1;
      tick();                                   // first edge after release
      v1 = 1'b0;
      chk_val("x_u1_busy", bz1, 1);
      tick();
      chk_val("x_u1_psel", ps1, 1);
      chk_val("x_u1_addr", pa1, 3);
      saw_rsp = 1'b0; saw_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rv8) saw_rsp = 1'b1;
         if (bz8) saw_busy = 1'b1;
      end
      chk_val("x_no_rsp8",  saw_rsp, 0);
      chk_val("x_no_busy8", saw_busy, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
